// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Four-phase signal controller. Each phase runs GREEN -> YELLOW -> ALLRED; the next phase
// is picked round-robin from pending demand when GREEN ends. P0 (main through) is the rest
// phase and holds green while nothing else is requested. emerg forces and holds P0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   per-phase request: [0] main through, [1] main turn, [2] side road, [3] ped
//   emerg      emergency preemption (level)
//   M1/MT/M2/S lamp codes: 3'b100 red, 3'b010 yellow, 3'b001 green
//   walk       pedestrian walk (P3 GREEN)
//   ped_clear  pedestrian clearance (P3 YELLOW)
//   phase      current phase index
//   state      2'b00 GREEN, 2'b01 YELLOW, 2'b10 ALLRED
module traffic_phase_scheduler #(
   parameter int unsigned GREEN_MIN = 4,
   parameter int unsigned GREEN_MAX = 8,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       emerg,
   output logic [2:0] M1,
   output logic [2:0] MT,
   output logic [2:0] M2,
   output logic [2:0] S,
   output logic       walk,
   output logic       ped_clear,
   output logic [1:0] phase,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StGreen  = 2'b00,
      StYellow = 2'b01,
      StAllred = 2'b10
   } state_e;

   localparam logic [2:0] LampRed    = 3'b100;
   localparam logic [2:0] LampYellow = 3'b010;
   localparam logic [2:0] LampGreen  = 3'b001;

   localparam logic [4:0] GreenMinM1  = 5'(GREEN_MIN - 1);
   localparam logic [4:0] GreenMaxM1  = 5'(GREEN_MAX - 1);
   localparam logic [4:0] YellowLast  = 5'(YELLOW_T - 1);
   localparam logic [4:0] AllredLast  = 5'(ALLRED_T - 1);

   state_e     state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [1:0] next_q, next_d;
   logic [4:0] count_q, count_d;
   logic [3:0] pending_q, pending_d;

   logic [3:0] demand;
   logic       other_demand;
   logic [3:0] clr;
   logic [1:0] rr_sel;
   logic       rr_found;
   logic [1:0] idx;
   logic [1:0] green_phase;
   logic [3:0] gmask;  // {S, M2, MT, M1} lamps that are green in the current phase

   // P0 is always wanted while we are away from it, so non-rest phases always terminate.
   assign demand       = pending_q | {3'b000, (phase_q != 2'd0)};
   assign other_demand = |(demand & ~(4'b0001 << phase_q));

   always_comb begin : next_state
      state_d     = state_q;
      phase_d     = phase_q;
      next_d      = next_q;
      count_d     = count_q;
      clr         = 4'b0000;
      rr_sel      = phase_q;
      rr_found    = 1'b0;
      idx         = phase_q;
      green_phase = next_q;

      for (int k = 1; k < 4; k++) begin
         idx = phase_q + 2'(k);
         if (!rr_found && demand[idx]) begin
            rr_sel   = idx;
            rr_found = 1'b1;
         end
      end

      unique case (state_q)
         StGreen: begin
            if (emerg && (phase_q != 2'd0)) begin
               state_d = StYellow;
               next_d  = 2'd0;
               count_d = '0;
            end else if (!emerg && other_demand &&
                         (((count_q >= GreenMinM1) && !req[phase_q]) ||
                          (count_q == GreenMaxM1))) begin
               state_d = StYellow;
               next_d  = rr_sel;
               count_d = '0;
            end else if (count_q != GreenMaxM1) begin
               count_d = count_q + 5'd1;
            end
         end
         StYellow: begin
            if (emerg) next_d = 2'd0;
            if (count_q == YellowLast) begin
               state_d = StAllred;
               count_d = '0;
            end else begin
               count_d = count_q + 5'd1;
            end
         end
         StAllred: begin
            if (emerg) next_d = 2'd0;
            if (count_q == AllredLast) begin
               green_phase = emerg ? 2'd0 : next_q;
               state_d     = StGreen;
               phase_d     = green_phase;
               count_d     = '0;
               clr         = 4'b0001 << green_phase;
            end else begin
               count_d = count_q + 5'd1;
            end
         end
         default: begin
            state_d = StAllred;
            count_d = '0;
         end
      endcase

      // Clear beats a same-cycle request; a held request re-sets the bit one cycle later.
      pending_d = (pending_q | req) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StAllred;
         phase_q   <= 2'd0;
         next_q    <= 2'd0;
         count_q   <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         next_q    <= next_d;
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin : lamp_decode
      gmask     = 4'b0000;
      M1        = LampRed;
      MT        = LampRed;
      M2        = LampRed;
      S         = LampRed;
      walk      = 1'b0;
      ped_clear = 1'b0;

      unique case (phase_q)
         2'd0: gmask = 4'b0101;
         2'd1: gmask = 4'b0011;
         2'd2: gmask = 4'b1000;
         2'd3: gmask = 4'b0000;
         default: gmask = 4'b0000;
      endcase

      if (state_q == StGreen) begin
         M1   = gmask[0] ? LampGreen : LampRed;
         MT   = gmask[1] ? LampGreen : LampRed;
         M2   = gmask[2] ? LampGreen : LampRed;
         S    = gmask[3] ? LampGreen : LampRed;
         walk = (phase_q == 2'd3);
      end else if (state_q == StYellow) begin
         M1        = gmask[0] ? LampYellow : LampRed;
         MT        = gmask[1] ? LampYellow : LampRed;
         M2        = gmask[2] ? LampYellow : LampRed;
         S         = gmask[3] ? LampYellow : LampRed;
         ped_clear = (phase_q == 2'd3);
      end
   end

   assign phase = phase_q;
   assign state = state_q;

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum green cycles per phase; legal range 1..GREEN_MAX.
REQ-002 Parameter GREEN_MAX, default 8, maximum green cycles per phase; legal range GREEN_MIN..31.
REQ-003 Parameter YELLOW_T, default 3, yellow/clearance cycles; legal range 1..31.
REQ-004 Parameter ALLRED_T, default 2, all-red cycles; legal range 1..31.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req  in  4  per-phase service request/detector: [0] main through, [1] main turn, [2] side road, [3] pedestrian.
REQ-008 emerg  in  1  emergency preemption, level; forces and holds phase P0.
REQ-009 M1, MT, M2, S  out  3 each  lamp codes: 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-010 walk  out  1  pedestrian walk indication.
REQ-011 ped_clear  out  1  pedestrian clearance indication.
REQ-012 phase  out  2  current phase index; state  out  2  00 GREEN, 01 YELLOW, 10 ALLRED.

Function
REQ-013 Phases: P0 M1=M2=green, MT=S=red; P1 M1=MT=green, M2=S=red; P2 S green, others red; P3 all vehicle red, walk=1.
REQ-014 Outputs are a Moore function of registered phase/state only; no input reaches outputs combinationally.
REQ-015 YELLOW: every lamp green in the current phase shows yellow, all others red; in P3 YELLOW walk=0, ped_clear=1.
REQ-016 ALLRED: all four lamps red, walk=0, ped_clear=0.
REQ-017 Counter (5 bits) clears to 0 on every state entry and increments each cycle, saturating at GREEN_MAX-1 in GREEN.
REQ-018 pending[i] sets on any cycle with req[i]=1 and clears on the cycle phase i enters GREEN; clear wins on a same-cycle collision, and a held req re-sets the bit next cycle.
REQ-019 Effective demand = pending, plus bit 0 forced to 1 while phase != P0 (P0 is the rest phase).
REQ-020 GREEN exit to YELLOW when demand exists for any other phase and either (count >= GREEN_MIN-1 and req[phase]=0) or count == GREEN_MAX-1.
REQ-021 With no demand for another phase, GREEN holds indefinitely.
REQ-022 Next phase is chosen at GREEN exit by round-robin search from phase+1 (mod 4) over effective demand, then latched.
REQ-023 YELLOW lasts exactly YELLOW_T cycles, then ALLRED.
REQ-024 ALLRED lasts exactly ALLRED_T cycles, then GREEN of the latched next phase.
REQ-025 emerg=1 in GREEN of phase != P0: YELLOW on the next edge, ignoring GREEN_MIN.
REQ-026 emerg=1 in YELLOW or ALLRED: the latched next phase is overridden to P0, and current timing completes normally.
REQ-027 emerg=1 in P0 GREEN: GREEN holds and ignores all demand; pending bits are retained and served normally after emerg falls.
REQ-028 Green-to-green transitions never occur; every phase change passes through YELLOW and then ALLRED.

Reset
REQ-029 On an rst edge: state=ALLRED, count=0, latched next phase=P0, pending=0, phase=P0.
REQ-030 During reset and the following ALLRED_T cycles: all lamps 3'b100, walk=0, ped_clear=0.
REQ-031 Reset asserted mid-operation (any state) takes effect at the next edge with no yellow step.

Verification
REQ-032 rst high 2 cycles, then low -> lamps all 100 for 2 cycles, then M1=M2=001, MT=S=100, phase=0.
REQ-033 No req for 50 cycles after reset -> P0 GREEN held throughout, state=00.
REQ-034 P0 idle, req[2] pulsed 1 cycle -> M1=M2=010 for 3 cycles, all red 2 cycles, S=001 for 4 cycles, S=010 for 3, all red 2, P0 green.
REQ-035 P0 idle, req[1], req[2], req[3] pulsed together -> phases served in order P1, P2, P3, P0; walk=1 only in P3 GREEN, ped_clear=1 for 3 cycles after.
REQ-036 In P2, req[2] held high and req[1] pending -> S green exactly 8 cycles, then yellow.
REQ-037 P2 GREEN count=1, emerg=1 held 20 cycles with req[1] pending -> S yellow next edge, all red, P0 held to emerg fall, then P1 served.
